hidden_backprop: RTL and testbench

//  Backward-pass counterpart of hidden_neuron: updates the four 8-bit input->hidden weights of one hidden neuron.

---
 rtl/hidden_backprop.sv | 199 +++++++++++++++++++
 tb/tb_hidden_backprop.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/hidden_backprop.sv
// rtl/hidden_backprop.sv - gradient-step update of the four input->hidden weights of one hidden neuron
//
// Purpose:
//   Backward-pass counterpart of hidden_neuron. The output-layer error is
//   propagated through this neuron's hidden->output weight and masked by the
//   ReLU derivative. Each of the four weights then takes one gradient step,
//   one weight per clock. The weights are staged in a shadow register and
//   committed to w_o all at once.
//
// Ports:
//   clk_i                in   1      clock, rising edge
//   rst_i                in   1      synchronous reset, active low
//   en_i                 in   1      backprop pass enable (level)
//   err_i                in   ERR_W  signed output error (final - target)
//   w_out_i              in   8      unsigned hidden->output weight
//   hidden_val_i         in   10     forward-pass hidden activation (post-ReLU)
//   x_i                  in   4      binary network inputs, bit k gates weight k
//   w_i                  in   32     current weights {w3,w2,w1,w0}
//   zero_weight_reset_i  in   1      end-of-update clear from the state machine
//   w_o                  out  32     committed weights {w3,w2,w1,w0}
//   busy_o               out  1      high in MUL/UPD
//   b_end_o              out  1      high in DONE

module hidden_backprop #(
  parameter int          ERR_W    = 24,
  parameter int          LR_SHIFT = 6,
  parameter logic [31:0] W_INIT   = 32'h04030201
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [ERR_W-1:0] err_i,
  input  logic [7:0]       w_out_i,
  input  logic [9:0]       hidden_val_i,
  input  logic [3:0]       x_i,
  input  logic [31:0]      w_i,
  input  logic             zero_weight_reset_i,
  output logic [31:0]      w_o,
  output logic             busy_o,
  output logic             b_end_o
);

  localparam int DW = ERR_W + 9;   // delta width
  localparam int NW = ERR_W + 10;  // updated-weight width before saturation

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    UPD  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Operands captured at E0; nothing outside is looked at again until IDLE.
  logic signed [ERR_W-1:0] err_q;
  logic [7:0]              w_out_q;
  logic [9:0]              hid_q;
  logic [3:0]              x_q;
  logic [31:0]             w_q;

  logic signed [DW-1:0]    delta_q;
  logic [1:0]              k_q;
  logic [31:0]             shadow_q;

  // Datapath intermediates
  logic signed [DW-1:0]    err_ext;
  logic signed [DW-1:0]    wout_ext;
  logic signed [DW-1:0]    product;
  logic [7:0]              w_cur;
  logic signed [DW-1:0]    g_k;
  logic signed [DW-1:0]    u_k;
  logic signed [NW-1:0]    n_k;
  logic [7:0]              sat_k;
  logic [31:0]             shadow_next;
  logic                    commit;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (en_i) state_d = MUL;
      MUL:  state_d = en_i ? UPD : IDLE;
      UPD: begin
        if (!en_i)           state_d = IDLE;
        else if (k_q == 2'd3) state_d = DONE;
      end
      DONE: if (zero_weight_reset_i || !en_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Outputs decoded from state
  // ---------------------------------------------------------------------
  always_comb begin
    busy_o  = 1'b0;
    b_end_o = 1'b0;
    case (state_q)
      MUL, UPD: busy_o  = 1'b1;
      DONE:     b_end_o = 1'b1;
      default: begin
        busy_o  = 1'b0;
        b_end_o = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Arithmetic
  // ---------------------------------------------------------------------
  always_comb begin
    // Both factors widened to the product width so the multiply is exact.
    err_ext  = {{(DW-ERR_W){err_q[ERR_W-1]}}, err_q};
    wout_ext = {{(DW-8){1'b0}}, w_out_q};
    product  = err_ext * wout_ext;

    w_cur = w_q[{k_q, 3'b000} +: 8];
    g_k   = x_q[k_q] ? delta_q : '0;
    // Arithmetic shift floors toward -inf, so small negative gradients still
    // move the weight by one.
    u_k   = g_k >>> LR_SHIFT;
    n_k   = $signed({{(NW-8){1'b0}}, w_cur}) - $signed({u_k[DW-1], u_k});

    if (n_k[NW-1]) begin
      sat_k = 8'd0;
    end else if (|n_k[NW-2:8]) begin
      sat_k = 8'd255;
    end else begin
      sat_k = n_k[7:0];
    end

    shadow_next = shadow_q;
    shadow_next[{k_q, 3'b000} +: 8] = sat_k;

    // The last weight goes straight from sat_k into w_o together with the
    // three already staged, so w_o never shows a partial update.
    commit = (state_q == UPD) && en_i && (k_q == 2'd3);
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      err_q    <= '0;
      w_out_q  <= '0;
      hid_q    <= '0;
      x_q      <= '0;
      w_q      <= '0;
      delta_q  <= '0;
      k_q      <= '0;
      shadow_q <= '0;
      w_o      <= W_INIT;
    end else begin
      case (state_q)
        IDLE: begin
          if (en_i) begin
            err_q   <= err_i;
            w_out_q <= w_out_i;
            hid_q   <= hidden_val_i;
            x_q     <= x_i;
            w_q     <= w_i;
          end
        end
        MUL: begin
          // ReLU derivative: a neuron that did not fire passes no gradient.
          delta_q <= (hid_q == 10'd0) ? '0 : product;
          k_q     <= 2'd0;
        end
        UPD: begin
          if (en_i) begin
            shadow_q <= shadow_next;
            k_q      <= k_q + 2'd1;
          end
          if (commit) begin
            w_o <= shadow_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hidden_backprop.sv
// tb/tb_hidden_backprop.sv - directed self-checking bench for hidden_backprop

module tb_hidden_backprop;

  localparam int          ERR_W  = 24;
  localparam logic [31:0] W_INIT = 32'h04030201;

  logic             clk_i;
  logic             rst_i;
  logic             en_i;
  logic [ERR_W-1:0] err_i;
  logic [7:0]       w_out_i;
  logic [9:0]       hidden_val_i;
  logic [3:0]       x_i;
  logic [31:0]      w_i;
  logic             zero_weight_reset_i;
  logic [31:0]      w_o;
  logic             busy_o;
  logic             b_end_o;

  int n_checks = 0;
  int n_fail   = 0;

  hidden_backprop dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .en_i                (en_i),
    .err_i               (err_i),
    .w_out_i             (w_out_i),
    .hidden_val_i        (hidden_val_i),
    .x_i                 (x_i),
    .w_i                 (w_i),
    .zero_weight_reset_i (zero_weight_reset_i),
    .w_o                 (w_o),
    .busy_o              (busy_o),
    .b_end_o             (b_end_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Advance one rising edge, then settle before sampling or driving.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [31:0] w, input logic [ERR_W-1:0] e,
                      input logic [7:0] wo, input logic [9:0] h, input logic [3:0] x);
    w_i          = w;
    err_i        = e;
    w_out_i      = wo;
    hidden_val_i = h;
    x_i          = x;
  endtask

  initial begin
    rst_i = 1'b0;
    en_i  = 1'b0;
    zero_weight_reset_i = 1'b0;
    load(32'h0, '0, 8'd0, 10'd0, 4'd0);
    step(2);

    // Reset state
    check("rst_w_o", w_o, W_INIT);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_b_end", {31'd0, b_end_o}, 32'd0);
    rst_i = 1'b1;
    step(1);
    check("idle_w_o", w_o, W_INIT);

    // Basic: delta = 64*2 = 128, u = 2, x=0101 updates w0 and w2
    load(32'h40302010, 24'd64, 8'd2, 10'd5, 4'b0101);
    en_i = 1'b1;
    step(1);                               // E0
    check("basic_busy_e0", {31'd0, busy_o}, 32'd1);
    // Inputs are latched at E0, so scribbling them now must not matter
    load(32'hFFFFFFFF, 24'hFFF000, 8'd255, 10'd0, 4'b1111);
    step(4);                               // E1..E4
    check("basic_w_o_e4", w_o, W_INIT);
    check("basic_b_end_e4", {31'd0, b_end_o}, 32'd0);
    check("basic_busy_e4", {31'd0, busy_o}, 32'd1);
    step(1);                               // E5
    check("basic_w_o_e5", w_o, 32'h402E200E);
    check("basic_b_end_e5", {31'd0, b_end_o}, 32'd1);
    check("basic_busy_e5", {31'd0, busy_o}, 32'd0);
    step(2);                               // DONE holds while en_i stays high
    check("done_hold_w_o", w_o, 32'h402E200E);
    check("done_hold_b_end", {31'd0, b_end_o}, 32'd1);
    zero_weight_reset_i = 1'b1;
    step(1);
    check("clear_b_end", {31'd0, b_end_o}, 32'd0);
    check("clear_w_o", w_o, 32'h402E200E);
    zero_weight_reset_i = 1'b0;
    en_i = 1'b0;
    step(1);

    // Negative / overflow saturation: delta = -32768, u = -512
    load(32'h40302010, -24'sd4096, 8'd8, 10'd1, 4'b1111);
    en_i = 1'b1;
    step(3);                               // E0..E2
    zero_weight_reset_i = 1'b1;            // ignored during UPD
    step(1);                               // E3
    zero_weight_reset_i = 1'b0;
    check("neg_w_o_e3", w_o, 32'h402E200E);
    step(2);                               // E4, E5
    check("neg_w_o_e5", w_o, 32'hFFFFFFFF);
    check("neg_b_end_e5", {31'd0, b_end_o}, 32'd1);
    en_i = 1'b0;
    step(1);
    check("neg_exit_b_end", {31'd0, b_end_o}, 32'd0);
    check("neg_exit_w_o", w_o, 32'hFFFFFFFF);

    // Underflow saturation: u = +512 on w0, w1
    load(32'h40302010, 24'd4096, 8'd8, 10'd1, 4'b0011);
    en_i = 1'b1;
    step(6);
    check("under_w_o", w_o, 32'h40300000);
    check("under_b_end", {31'd0, b_end_o}, 32'd1);
    en_i = 1'b0;
    step(1);

    // ReLU mask: hidden value 0 leaves every weight untouched
    load(32'h12345678, 24'd1000, 8'd200, 10'd0, 4'b1111);
    en_i = 1'b1;
    step(5);
    check("relu_b_end_e4", {31'd0, b_end_o}, 32'd0);
    step(1);
    check("relu_w_o", w_o, 32'h12345678);
    check("relu_b_end", {31'd0, b_end_o}, 32'd1);
    en_i = 1'b0;
    step(1);

    // Abort: en_i low at E3 discards the shadow
    load(32'h00000000, 24'd4096, 8'd8, 10'd1, 4'b1111);
    en_i = 1'b1;
    step(3);                               // E0..E2
    en_i = 1'b0;
    step(1);                               // E3
    check("abort_busy", {31'd0, busy_o}, 32'd0);
    check("abort_b_end", {31'd0, b_end_o}, 32'd0);
    step(4);
    check("abort_w_o", w_o, 32'h12345678);
    check("abort_b_end_late", {31'd0, b_end_o}, 32'd0);

    // Reset mid-UPD at E4 wins over the pass
    load(32'h40302010, 24'd64, 8'd2, 10'd5, 4'b0101);
    en_i = 1'b1;
    step(4);                               // E0..E3
    rst_i = 1'b0;
    step(1);                               // E4
    check("midrst_w_o", w_o, W_INIT);
    check("midrst_busy", {31'd0, busy_o}, 32'd0);
    check("midrst_b_end", {31'd0, b_end_o}, 32'd0);
    rst_i = 1'b1;
    step(3);
    check("midrst_hold_w_o", w_o, W_INIT);
    check("midrst_hold_b_end", {31'd0, b_end_o}, 32'd0);
    en_i = 1'b0;
    step(1);

    // Fresh pass after reset completes normally
    en_i = 1'b1;
    step(6);
    check("fresh_w_o", w_o, 32'h402E200E);
    check("fresh_b_end", {31'd0, b_end_o}, 32'd1);
    en_i = 1'b0;
    step(1);
    check("fresh_idle_b_end", {31'd0, b_end_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
